// File: rtl/data_memory_ctrl.sv
// Data memory controller: single-outstanding load/store engine in front of a
// byte-addressable, big-endian memory. Each request passes through IDLE, an
// optional WAIT phase of WAIT_STATES cycles, and a one-cycle RESP phase.
// Bounds and alignment are checked so that rejected accesses never touch memory.
// The memory is split into four byte-lane banks, indexed by addr[1:0], so that
// aligned half and word accesses hit one row in every bank at the same time.
module data_memory_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
);

    localparam int BANK_DEPTH = DEPTH_BYTES / 4;
    localparam int IDX_W      = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int EXT_W      = ADDR_WIDTH + 1;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic [3:0] count_reg, count_next;
    logic       accept;
    logic       commit;

    // Registered request fields, captured on accept
    logic                  write_reg;
    logic [1:0]            size_reg;
    logic                  unsigned_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]           wdata_reg;

    // Effective request: the live inputs while idle (needed when there are no
    // wait states and the commit edge is the accept edge), the registers after
    logic                  cur_write;
    logic [1:0]            cur_size;
    logic                  cur_unsigned;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [2:0]            cur_bytes;
    logic [EXT_W-1:0]      cur_end;
    logic                  cur_err;
    logic [IDX_W-1:0]      cur_idx;

    // Response formatting state, captured on the edge entering RESP so the
    // output holds steady until the next response even after a new accept
    logic       resp_error_reg;
    logic       fmt_zero_reg;
    logic [1:0] fmt_size_reg;
    logic       fmt_unsigned_reg;
    logic [1:0] fmt_off_reg;
    logic [31:0] rd_word;

    assign accept     = req_valid && req_ready;
    assign req_ready  = (state_reg == S_IDLE) && rst_n;
    assign resp_valid = (state_reg == S_RESP);
    assign resp_error = resp_error_reg;
    assign cur_idx    = cur_addr[IDX_W+1:2];

    // Select the request the datapath acts on this cycle
    always_comb begin
        if (state_reg == S_IDLE) begin
            cur_write    = req_write;
            cur_size     = req_size;
            cur_unsigned = req_unsigned;
            cur_addr     = req_addr;
            cur_wdata    = req_wdata;
        end else begin
            cur_write    = write_reg;
            cur_size     = size_reg;
            cur_unsigned = unsigned_reg;
            cur_addr     = addr_reg;
            cur_wdata    = wdata_reg;
        end
    end

    // Access legality: reserved size, misalignment, or last byte beyond the end.
    // The end address is one bit wider than the address so it cannot wrap.
    always_comb begin
        case (cur_size)
            2'b00:   cur_bytes = 3'd1;
            2'b01:   cur_bytes = 3'd2;
            default: cur_bytes = 3'd4;
        endcase
        cur_end = {1'b0, cur_addr} + EXT_W'(cur_bytes) - EXT_W'(1);
        cur_err = (cur_size == 2'b11)
               || ((cur_size == 2'b01) && cur_addr[0])
               || ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00))
               || (cur_end >= EXT_W'(DEPTH_BYTES));
    end

    // Next-state logic; commit marks the edge that enters RESP
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        commit     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = S_RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        count_next = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (count_reg == 4'd0) begin
                    state_next = S_RESP;
                    commit     = 1'b1;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    // State and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            count_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Capture the request fields on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_reg    <= 1'b0;
            size_reg     <= 2'b00;
            unsigned_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= 32'h0;
        end else if (accept) begin
            write_reg    <= req_write;
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            addr_reg     <= req_addr;
            wdata_reg    <= req_wdata;
        end
    end

    // Capture error flag and load formatting controls on the edge entering RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_error_reg   <= 1'b0;
            fmt_zero_reg     <= 1'b1;
            fmt_size_reg     <= 2'b00;
            fmt_unsigned_reg <= 1'b0;
            fmt_off_reg      <= 2'b00;
        end else if (commit) begin
            resp_error_reg   <= cur_err;
            fmt_zero_reg     <= cur_err || cur_write;
            fmt_size_reg     <= cur_size;
            fmt_unsigned_reg <= cur_unsigned;
            fmt_off_reg      <= cur_addr[1:0];
        end
    end

    // One bank per byte lane; lane gi holds every byte whose addr[1:0] == gi
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] bank [BANK_DEPTH];
            logic [7:0] rd_reg;
            logic       we;
            logic [7:0] wd;

            // Lane write enable and big-endian data steering for stores
            always_comb begin
                we = 1'b0;
                wd = 8'h00;
                if (commit && cur_write && !cur_err) begin
                    case (cur_size)
                        2'b00: begin
                            we = (cur_addr[1:0] == 2'(gi));
                            wd = cur_wdata[7:0];
                        end
                        2'b01: begin
                            we = (cur_addr[1] == 1'(gi / 2));
                            wd = ((gi % 2) == 0) ? cur_wdata[15:8] : cur_wdata[7:0];
                        end
                        2'b10: begin
                            we = 1'b1;
                            wd = cur_wdata[31-8*gi -: 8];
                        end
                        default: begin
                            we = 1'b0;
                        end
                    endcase
                end
            end

            // Synchronous write and registered read of this lane's bank
            always_ff @(posedge clk) begin
                if (we) begin
                    bank[cur_idx] <= wd;
                end
                if (commit) begin
                    rd_reg <= bank[cur_idx];
                end
            end

            assign rd_word[31-8*gi -: 8] = rd_reg;
        end
    endgenerate

    // Right-align and extend the captured row; stores and errors read as zero
    always_comb begin
        logic [15:0] half_sel;
        logic [7:0]  byte_sel;
        half_sel = fmt_off_reg[1] ? rd_word[15:0] : rd_word[31:16];
        case (fmt_off_reg)
            2'd0:    byte_sel = rd_word[31:24];
            2'd1:    byte_sel = rd_word[23:16];
            2'd2:    byte_sel = rd_word[15:8];
            default: byte_sel = rd_word[7:0];
        endcase
        case (fmt_size_reg)
            2'b00:   resp_rdata = fmt_unsigned_reg ? {24'h0, byte_sel}
                                                   : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   resp_rdata = fmt_unsigned_reg ? {16'h0, half_sel}
                                                   : {{16{half_sel[15]}}, half_sel};
            default: resp_rdata = rd_word;
        endcase
        if (fmt_zero_reg) begin
            resp_rdata = 32'h0;
        end
    end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024: byte capacity; a multiple of 4, at least 4.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: request address width.
REQ-003 SHALL have parameter WAIT_STATES, default 2, legal 0..15: extra access cycles.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-010 SHALL have port req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-011 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-012 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-013 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-014 SHALL have port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 SHALL have port resp_error  output  1  access rejected; qualified by resp_valid.

Function
REQ-016 SHALL implement FSM IDLE, WAIT, RESP; req_ready = 1 only in IDLE with rst_n high.
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, registering write, size, unsigned, addr, wdata.
REQ-018 On accept: if WAIT_STATES = 0, SHALL go IDLE->RESP; otherwise IDLE->WAIT, loading the counter with WAIT_STATES-1.
REQ-019 In WAIT, SHALL decrement the counter each edge; at counter = 0, SHALL go WAIT->RESP.
REQ-020 RESP SHALL last exactly one cycle, then go to IDLE; resp_valid = 1 only in RESP.
REQ-021 Latency: with the accept at edge E0, resp_valid SHALL be high in the cycle after edge E0+WAIT_STATES.
REQ-022 A new request SHALL be accepted no earlier than the edge ending RESP, giving a throughput of 1 per WAIT_STATES+2 cycles.
REQ-023 The store commit and the load capture into resp_rdata SHALL both occur on the edge entering RESP.
REQ-024 Byte order SHALL be big-endian: the byte at addr maps to the most significant bits.
REQ-025 Word store SHALL write mem[a..a+3] = wdata[31:24], [23:16], [15:8], [7:0].
REQ-026 Half store SHALL write mem[a] = wdata[15:8] and mem[a+1] = wdata[7:0].
REQ-027 Byte store SHALL write mem[a] = wdata[7:0].
REQ-028 Half and byte loads SHALL right-align the data, then zero- or sign-extend it per req_unsigned.
REQ-029 Word load SHALL return {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
REQ-030 SHALL flag an error for any of: size 11; half with a odd; word with a[1:0] != 0; a+bytes-1 >= DEPTH_BYTES.
REQ-031 Out-of-range comparison SHALL use full ADDR_WIDTH+1 arithmetic so that wrap-around cannot alias into range.
REQ-032 An errored access SHALL write nothing and return resp_rdata = 0 and resp_error = 1, with the same latency as a valid access.
REQ-033 Outside RESP, resp_rdata and resp_error SHALL hold their last values; only resp_valid qualifies them.
REQ-034 Request inputs SHALL be ignored while req_ready = 0.

Reset
REQ-035 While rst_n = 0: state = IDLE, counter = 0, resp_valid = 0, resp_error = 0, resp_rdata = 0, req_ready = 0.
REQ-036 Reset assertion SHALL take effect immediately, independent of clk.
REQ-037 Reset during WAIT SHALL abort the access; a pending store is discarded, with no memory write and no response.
REQ-038 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-039 WAIT_STATES = 2: store word 0xDEADBEEF at addr 0x10, then load word at 0x10 -> resp_rdata = 0xDEADBEEF, resp_valid in the cycle after E0+2, req_ready low for 3 cycles per access.
REQ-040 After REQ-039: load byte at 0x11, signed -> 0xFFFFFFAD; unsigned -> 0x000000AD; load half at 0x12, signed -> 0xFFFFBEEF.
REQ-041 Store half 0x1234 at 0x13 -> resp_error = 1 and mem[0x13..0x14] unchanged; load word at 0x3FE -> error, resp_rdata = 0; load word at 0xFFFFFFFC -> error, no alias to low memory.
REQ-042 WAIT_STATES = 0: back-to-back byte store then load at 0x20 with data 0x7F -> each response in the cycle after its accept, accepts 2 cycles apart, load returns 0x0000007F.
REQ-043 Pulse rst_n low during WAIT of a word store of 0xCAFEBABE to 0x40 -> no resp_valid, and a later load of 0x40 returns the prior contents.
REQ-044 req_valid held high with changing addr during WAIT -> only the first request is accepted, and the response matches it.
